// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: host-to-SRAM initiator. It accepts one request at a time
// and sequences the RAM strobes for it. A write is a single ram_wr cycle. A
// read holds ram_rd for RD_LAT cycles, samples ram_din at the end of the last
// cycle, and returns the word on a one-cycle rsp_valid strobe.
// Optional feature macro: READBACK_VERIFY_EN. When it is defined, every write
// is followed by a read-back of the same address (VERIFY state), and a
// response is sent with rsp_err set if the word read back differs from the
// word written.
module sram_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP
`ifdef READBACK_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef READBACK_VERIFY_EN
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_err_q;

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Controller FSM; every output is registered and set on the transition into
  // the state that owns it. ram_add/ram_dout change only at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      ram_wr    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_add   <= '0;
      ram_dout  <= '0;
`ifdef READBACK_VERIFY_EN
      wdata_q   <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            ram_add   <= req_addr;
`ifdef READBACK_VERIFY_EN
            wdata_q   <= req_wdata;
`endif
            if (req_we) begin
              state    <= WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= req_wdata;
            end else begin
              state  <= READ;
              ram_rd <= 1'b1;
              cnt    <= CNT_W'(RD_LAT);
            end
          end
        end

        WRITE: begin
          ram_wr <= 1'b0;
`ifdef READBACK_VERIFY_EN
          // Read back the word just written, using the normal read timing.
          state  <= VERIFY;
          ram_rd <= 1'b1;
          cnt    <= CNT_W'(RD_LAT);
`else
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
`endif
        end

        READ: begin
          if (cnt == CNT_W'(1)) begin
            // This edge ends the last ram_rd cycle, so ram_din is valid now.
            ram_rd    <= 1'b0;
            rsp_rdata <= ram_din;
            rsp_valid <= 1'b1;
`ifdef READBACK_VERIFY_EN
            rsp_err_q <= 1'b0;
`endif
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

`ifdef READBACK_VERIFY_EN
        VERIFY: begin
          if (cnt == CNT_W'(1)) begin
            ram_rd    <= 1'b0;
            rsp_rdata <= ram_din;
            rsp_err_q <= (ram_din != wdata_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif

        RESP: begin
          rsp_valid <= 1'b0;
`ifdef READBACK_VERIFY_EN
          rsp_err_q <= 1'b0;
`endif
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          ram_wr    <= 1'b0;
          ram_rd    <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
